axis_frame_guard: RTL and testbench
===================================

# axis_frame_guard

Per-frame length policer on an AXI4-Stream path, placed directly upstream of `axis_frame_fifo` instances that run with frame-FIFO dropping and bad-frame dropping enabled. It counts bytes per frame and handles out-of-range frames as follows:
- Oversize frames are truncated at the word that crosses `MAX_LEN`. That word carries the bad-frame tuser marker and the rest of the frame is discarded.
- Runt frames shorter than `MIN_LEN` are marked bad on their tlast word.

The downstream FIFO then drops both kinds by tuser.

## Interface
**Parameters**
- `DATA_WIDTH`, default 8: tdata width in bits.
- `KEEP_ENABLE`, default (DATA_WIDTH>8): propagate tkeep and use it for byte counting. When 0, tkeep is treated as all ones.
- `KEEP_WIDTH`, default (DATA_WIDTH/8): tkeep width.
- `USER_WIDTH`, default 1: tuser width.
- `LEN_WIDTH`, default 16: frame byte counter width.
- `MIN_LEN`, default 64: minimum legal frame length in bytes.
- `MAX_LEN`, default 1518: maximum legal frame length in bytes. Must satisfy MIN_LEN ≤ MAX_LEN < 2**LEN_WIDTH.
- `USER_BAD_FRAME_VALUE`, default 1'b1: tuser value written on bad frames.
- `USER_BAD_FRAME_MASK`, default 1'b1: tuser bits that are overwritten.

**Ports**
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `s_axis_tdata`, `s_axis_tkeep`, `s_axis_tvalid`, `s_axis_tready` (output), `s_axis_tlast`, `s_axis_tuser`: input stream, widths per parameters.
- `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tvalid`, `m_axis_tready` (input), `m_axis_tlast`, `m_axis_tuser`: output stream.
- `status_truncated`, output, 1: one-cycle pulse when an oversize frame is truncated.
- `status_runt`, output, 1: one-cycle pulse when a runt frame is marked.
- `status_frame_len`, output, LEN_WIDTH: byte length of the last completed frame (see Configuration).
- `status_frame_len_valid`, output, 1: one-cycle pulse qualifying `status_frame_len`.

## Operation
- **Byte count per accepted word:**
  - `n` = popcount(tkeep), or KEEP_WIDTH when KEEP_ENABLE=0.
  - `sum` = len_reg + n, computed in LEN_WIDTH+1 bits.
  - len_reg saturates at 2**LEN_WIDTH−1.
- **State PASS** (reset state). Each accepted word is forwarded, with these rules applied in order:
  - If `sum` > MAX_LEN: forward the word with tlast forced to 1 and the tuser bad marker applied. Pulse `status_truncated` and reset len_reg to 0. Go to DROP unless the input tlast=1, in which case stay in PASS.
  - Otherwise, if tlast=1 and `sum` < MIN_LEN: apply the tuser bad marker, pulse `status_runt`, and reset len_reg to 0.
  - Otherwise, if tlast=1: forward unchanged and reset len_reg to 0.
  - Otherwise: forward unchanged and set len_reg to `sum`.
- **Bad marker:** tuser_out = (tuser & ~MASK) | (VALUE & MASK). tdata and tkeep are never modified.
- **State DROP:**
  - s_axis_tready=1 unconditionally. Words are consumed and never forwarded.
  - An accepted word with tlast=1 returns the block to PASS with len_reg=0.
- **Boundaries:**
  - Frame length exactly MAX_LEN passes unmarked.
  - Frame length exactly MIN_LEN passes unmarked.
  - Words with tkeep=0 add 0 bytes.
  - Input frames already marked bad pass with their tuser unchanged unless a rule above applies.
- **Reset mid-frame:**
  - State goes to PASS, len_reg to 0, and the skid buffer is emptied.
  - A partial frame already emitted is left without tlast. Recovery of that frame is the downstream FIFO's responsibility.

## Timing
- **Output stage:** a registered output stage plus one skid register.
  - Full throughput: 1 word/cycle.
  - Latency: 1 cycle from input acceptance to m_axis_tvalid.
- **s_axis_tready:**
  - Registered. Equals 1 when the skid register is empty, or when the state is DROP.
  - Deasserts one cycle after m_axis_tready backpressure would overflow the output stage.
- **Handshake rules:**
  - m_axis_tvalid never depends combinationally on s_axis_tvalid.
  - Once asserted, m_axis_tvalid and the m_axis data are held stable until m_axis_tready.
- **Status timing:** status pulses assert in the cycle after the triggering input word is accepted, aligned with that word entering the output stage.
- **Reset values:** m_axis_tvalid=0, s_axis_tready=0 during rst and 1 the cycle after, all status outputs 0, status_frame_len=0.

## Configuration
- **`AXIS_FRAME_GUARD_LEN_REPORT_EN` defined:**
  - On every frame end, whether real tlast or truncation, `status_frame_len` takes the saturated byte count of the emitted frame, including the last word.
  - `status_frame_len_valid` pulses for 1 cycle.
- **Macro undefined:**
  - Both outputs are tied to 0.
  - No extra register beyond len_reg is instantiated.

## Structure
- **Shared package `axis_pkg`:**
  - State enum {PASS, DROP}.
  - Popcount function.
  - Bad-marker merge function (tuser, value, mask).
- **One sub-module, `axis_skid_reg`:** the generic one-word skid/output register with a tdata/tkeep/tlast/tuser payload, reusable by the other stream blocks.

## Test plan
All scenarios use DATA_WIDTH=8, MIN_LEN=4, MAX_LEN=8 unless noted.
- **Legal frames:** 4-byte and 8-byte frames, m_axis_tready=1 → both output unchanged, tuser=0, no status pulses, latency 1 cycle, back-to-back with no bubbles.
- **Runt:** 3-byte frame → 3 words out, tlast word tuser=1, status_runt pulses once.
- **Oversize:** 12-byte frame → exactly 9 words out, word 9 has tlast=1 and tuser=1, status_truncated pulses, input words 10–12 consumed with s_axis_tready=1. The next 5-byte frame passes clean.
- **Keep counting:** DATA_WIDTH=32, MAX_LEN=10, frame of 3 words with tkeep 1111, 1111, 0011 → 10 bytes, unmarked. The same frame with final tkeep 0111 → 11 bytes, truncated on word 3.
- **Backpressure:** random m_axis_tready at 30% duty across 200 mixed frames → scoreboard matches the reference model, no word lost or duplicated, output held stable while stalled.
- **Reset:** rst asserted mid-way through a 6-byte frame and again while in DROP → m_axis_tvalid=0 next cycle. The first frame after reset is counted from 0 and passes clean. With `AXIS_FRAME_GUARD_LEN_REPORT_EN`, `status_frame_len` reads 0 until the next frame end.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI4-Stream helpers: guard FSM states, byte popcount, bad-frame tuser merge.
package axis_pkg;

  typedef enum logic {
    PASS = 1'b0,
    DROP = 1'b1
  } guard_state_e;

  // Sideband fields (tkeep/tuser) up to this width are handled by the helpers.
  localparam int unsigned AXIS_SIDE_MAX_W = 64;

  // Number of set bits; callers zero-extend narrower tkeep vectors.
  function automatic int unsigned popcount(input logic [AXIS_SIDE_MAX_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < AXIS_SIDE_MAX_W; i++) c += {31'd0, v[i]};
    return c;
  endfunction

  // Overwrite the masked tuser bits with the bad-frame value, keep the rest.
  function automatic logic [AXIS_SIDE_MAX_W-1:0] bad_merge(
    input logic [AXIS_SIDE_MAX_W-1:0] user,
    input logic [AXIS_SIDE_MAX_W-1:0] value,
    input logic [AXIS_SIDE_MAX_W-1:0] mask
  );
    return (user & ~mask) | (value & mask);
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// One-word output register plus one skid register for an AXI4-Stream beat.
// s_tready_o is registered; output payload is held while m_tvalid_o && !m_tready_i.
module axis_skid_reg #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic [KEEP_WIDTH-1:0] s_tkeep_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  input  logic                  s_tlast_i,
  input  logic [USER_WIDTH-1:0] s_tuser_i,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic [KEEP_WIDTH-1:0] m_tkeep_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic                  m_tlast_o,
  output logic [USER_WIDTH-1:0] m_tuser_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  beat_t in_beat, out_q, skid_q;
  logic  out_vld_q, skid_vld_q, rdy_q, rdy_d;

  assign in_beat = '{data: s_tdata_i, keep: s_tkeep_i, last: s_tlast_i, user: s_tuser_i};

  // Stay ready next cycle unless the output is stalled and the skid is (or is about to be) full.
  assign rdy_d = m_tready_i | (~skid_vld_q & (~out_vld_q | ~s_tvalid_i));

  // Valid flags and registered ready; an empty skid after reset means ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      rdy_q <= rdy_d;
      if (rdy_q) begin
        if (m_tready_i || !out_vld_q) out_vld_q  <= s_tvalid_i;
        else                          skid_vld_q <= s_tvalid_i;
      end else if (m_tready_i) begin
        out_vld_q  <= skid_vld_q;
        skid_vld_q <= 1'b0;
      end
    end
  end

  // Payload follows the same routing as the valid flags; contents are don't-care while invalid.
  always_ff @(posedge clk_i) begin
    if (rdy_q) begin
      if (m_tready_i || !out_vld_q) out_q  <= in_beat;
      else                          skid_q <= in_beat;
    end else if (m_tready_i) begin
      out_q <= skid_q;
    end
  end

  assign s_tready_o = rdy_q;
  assign m_tvalid_o = out_vld_q;
  assign m_tdata_o  = out_q.data;
  assign m_tkeep_o  = out_q.keep;
  assign m_tlast_o  = out_q.last;
  assign m_tuser_o  = out_q.user;

endmodule

// File: rtl/axis_frame_guard.sv
// Per-frame byte-length policer: truncates oversize frames (marking the cut word bad and
// discarding the remainder) and marks runt frames bad on their tlast word.
// Optional: define AXIS_FRAME_GUARD_LEN_REPORT_EN to report each emitted frame's length.
module axis_frame_guard
  import axis_pkg::*;
#(
  parameter int                    DATA_WIDTH           = 8,
  parameter bit                    KEEP_ENABLE          = (DATA_WIDTH > 8),
  parameter int                    KEEP_WIDTH           = (DATA_WIDTH / 8),
  parameter int                    USER_WIDTH           = 1,
  parameter int                    LEN_WIDTH            = 16,
  parameter int                    MIN_LEN              = 64,
  parameter int                    MAX_LEN              = 1518,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = USER_WIDTH'(1),
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = USER_WIDTH'(1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  status_truncated,
  output logic                  status_runt,
  output logic [LEN_WIDTH-1:0]  status_frame_len,
  output logic                  status_frame_len_valid
);

  localparam logic [LEN_WIDTH:0] MIN_L = (LEN_WIDTH + 1)'(MIN_LEN);
  localparam logic [LEN_WIDTH:0] MAX_L = (LEN_WIDTH + 1)'(MAX_LEN);

  guard_state_e          state_q;
  logic [LEN_WIDTH-1:0]  len_q, sum_sat;
  logic [LEN_WIDTH:0]    n_bytes, sum;
  logic [KEEP_WIDTH-1:0] keep_in;
  logic [USER_WIDTH-1:0] fwd_user;
  logic                  accept, fwd_vld, fwd_last, over, runt;
  logic                  skid_rdy, trunc_q, runt_q;

  // In DROP everything is swallowed, so ready no longer depends on the output stage.
  assign s_axis_tready = ~rst & ((state_q == DROP) | skid_rdy);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign fwd_vld       = accept & (state_q == PASS);
  assign keep_in       = KEEP_ENABLE ? s_axis_tkeep : '1;

  // Byte accounting for the current word and the policing decision it triggers.
  always_comb begin
    n_bytes  = KEEP_ENABLE ? (LEN_WIDTH + 1)'(popcount(AXIS_SIDE_MAX_W'(s_axis_tkeep)))
                           : (LEN_WIDTH + 1)'(KEEP_WIDTH);
    sum      = {1'b0, len_q} + n_bytes;
    sum_sat  = sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
    over     = (sum > MAX_L);
    runt     = s_axis_tlast && (sum < MIN_L);
    fwd_last = s_axis_tlast | over;
    fwd_user = (over || runt)
             ? USER_WIDTH'(bad_merge(AXIS_SIDE_MAX_W'(s_axis_tuser),
                                     AXIS_SIDE_MAX_W'(USER_BAD_FRAME_VALUE),
                                     AXIS_SIDE_MAX_W'(USER_BAD_FRAME_MASK)))
             : s_axis_tuser;
  end

`ifdef AXIS_FRAME_GUARD_LEN_REPORT_EN
  logic [LEN_WIDTH-1:0] flen_q;
  logic                 flen_vld_q;
`endif

  // Policing FSM: frame length counter, PASS/DROP state and registered status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PASS;
      len_q   <= '0;
      trunc_q <= 1'b0;
      runt_q  <= 1'b0;
`ifdef AXIS_FRAME_GUARD_LEN_REPORT_EN
      flen_q     <= '0;
      flen_vld_q <= 1'b0;
`endif
    end else begin
      trunc_q <= 1'b0;
      runt_q  <= 1'b0;
`ifdef AXIS_FRAME_GUARD_LEN_REPORT_EN
      flen_vld_q <= 1'b0;
`endif
      if (accept) begin
        case (state_q)
          PASS: begin
            if (over || s_axis_tlast) begin
              // Frame ends here, either naturally or by truncation.
              len_q   <= '0;
              trunc_q <= over;
              runt_q  <= runt & ~over;
              if (over && !s_axis_tlast) state_q <= DROP;
`ifdef AXIS_FRAME_GUARD_LEN_REPORT_EN
              flen_q     <= sum_sat;
              flen_vld_q <= 1'b1;
`endif
            end else begin
              len_q <= sum_sat;
            end
          end
          DROP: begin
            if (s_axis_tlast) begin
              state_q <= PASS;
              len_q   <= '0;
            end
          end
          default: state_q <= PASS;
        endcase
      end
    end
  end

  assign status_truncated = trunc_q;
  assign status_runt      = runt_q;
`ifdef AXIS_FRAME_GUARD_LEN_REPORT_EN
  assign status_frame_len       = flen_q;
  assign status_frame_len_valid = flen_vld_q;
`else
  assign status_frame_len       = '0;
  assign status_frame_len_valid = 1'b0;
`endif

  axis_skid_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH),
    .USER_WIDTH (USER_WIDTH)
  ) u_out (
    .clk_i      (clk),
    .rst_i      (rst),
    .s_tdata_i  (s_axis_tdata),
    .s_tkeep_i  (keep_in),
    .s_tvalid_i (fwd_vld),
    .s_tready_o (skid_rdy),
    .s_tlast_i  (fwd_last),
    .s_tuser_i  (fwd_user),
    .m_tdata_o  (m_axis_tdata),
    .m_tkeep_o  (m_axis_tkeep),
    .m_tvalid_o (m_axis_tvalid),
    .m_tready_i (m_axis_tready),
    .m_tlast_o  (m_axis_tlast),
    .m_tuser_o  (m_axis_tuser)
  );

endmodule

// File: tb/tb_axis_frame_guard.sv
// Directed bench for axis_frame_guard: 8-bit instance (MIN 4, MAX 8) and a 32-bit
// keep-counting instance (MIN 4, MAX 10), plus a randomly back-pressured scoreboard run.
module tb_axis_frame_guard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance
  logic [7:0]  s_data = '0;
  logic [0:0]  s_keep = '1;
  logic        s_valid = 1'b0, s_last = 1'b0;
  logic [0:0]  s_user = '0;
  logic        s_ready;
  logic [7:0]  m_data;
  logic [0:0]  m_keep;
  logic        m_valid, m_last;
  logic        m_ready = 1'b1;
  logic [0:0]  m_user;
  logic        st_tr, st_rn, st_lv;
  logic [15:0] st_len;

  axis_frame_guard #(.DATA_WIDTH(8), .MIN_LEN(4), .MAX_LEN(8)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
    .s_axis_tready(s_ready), .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
    .m_axis_tready(m_ready), .m_axis_tlast(m_last), .m_axis_tuser(m_user),
    .status_truncated(st_tr), .status_runt(st_rn),
    .status_frame_len(st_len), .status_frame_len_valid(st_lv));

  // 32-bit instance
  logic [31:0] t_data = '0;
  logic [3:0]  t_keep = '1;
  logic        t_valid = 1'b0, t_last = 1'b0;
  logic [0:0]  t_user = '0;
  logic        t_ready;
  logic [31:0] u_data;
  logic [3:0]  u_keep;
  logic        u_valid, u_last;
  logic        u_ready = 1'b1;
  logic [0:0]  u_user;
  logic        u_tr, u_rn, u_lv;
  logic [15:0] u_len;

  axis_frame_guard #(.DATA_WIDTH(32), .MIN_LEN(4), .MAX_LEN(10)) dut32 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(t_data), .s_axis_tkeep(t_keep), .s_axis_tvalid(t_valid),
    .s_axis_tready(t_ready), .s_axis_tlast(t_last), .s_axis_tuser(t_user),
    .m_axis_tdata(u_data), .m_axis_tkeep(u_keep), .m_axis_tvalid(u_valid),
    .m_axis_tready(u_ready), .m_axis_tlast(u_last), .m_axis_tuser(u_user),
    .status_truncated(u_tr), .status_runt(u_rn),
    .status_frame_len(u_len), .status_frame_len_valid(u_lv));

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Output monitors, sampled mid-cycle
  logic [9:0] obs_q[$];
  logic [5:0] obs32_q[$];
  int obs_tr, obs_rn, obs_lv, o32_tr, o32_rn, o32_lv;
  bit stall_q = 0;
  logic [9:0] held;

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_q) begin
        chk("hold_vld", m_valid, 1'b1);
        chk("hold_dat", {m_data, m_last, m_user}, held);
      end
      stall_q = m_valid && !m_ready;
      held = {m_data, m_last, m_user};
      if (m_valid && m_ready) obs_q.push_back({m_data, m_last, m_user});
      if (u_valid && u_ready) obs32_q.push_back({u_keep, u_last, u_user});
      obs_tr += int'(st_tr); obs_rn += int'(st_rn); obs_lv += int'(st_lv);
      o32_tr += int'(u_tr);  o32_rn += int'(u_rn);  o32_lv += int'(u_lv);
    end else stall_q = 0;
  end

  // Reference model for the scoreboard run (MIN 4, MAX 8, 1 byte per word)
  logic [9:0] exp_q[$];
  int m_len = 0, exp_tr = 0, exp_rn = 0;
  bit m_drop = 0, use_model = 0;

  task automatic model(input logic [7:0] d, input logic l, input logic u);
    if (m_drop) begin
      if (l) m_drop = 0;
    end else if (m_len + 1 > 8) begin
      exp_q.push_back({d, 1'b1, 1'b1}); exp_tr++; m_len = 0; m_drop = !l;
    end else if (l && m_len + 1 < 4) begin
      exp_q.push_back({d, 1'b1, 1'b1}); exp_rn++; m_len = 0;
    end else begin
      exp_q.push_back({d, l, u}); m_len = l ? 0 : m_len + 1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic u);
    bit acc;
    int t;
    acc = 0; t = 0;
    s_data = d; s_last = l; s_user = u; s_valid = 1'b1;
    do begin
      @(negedge clk); acc = s_ready;
      @(posedge clk); #1; t++;
    end while (!acc && t < 1000);
    if (!acc) chk("send_timeout", 0, 1);
    else if (use_model) model(d, l, u);
    s_valid = 1'b0;
  endtask

  task automatic send32(input logic [3:0] k, input logic l);
    bit acc;
    int t;
    acc = 0; t = 0;
    t_data = 32'hA5A5_0000 | 32'(k); t_keep = k; t_last = l; t_valid = 1'b1;
    do begin
      @(negedge clk); acc = t_ready;
      @(posedge clk); #1; t++;
    end while (!acc && t < 1000);
    if (!acc) chk("send32_timeout", 0, 1);
    t_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input int n, input logic u);
    for (int i = 0; i < n; i++) send(base + 8'(i), i == n - 1, u);
  endtask

  task automatic drain();
    repeat (5) @(posedge clk);
    #1;
  endtask

  // Pops n words and compares with base+i data, tlast on the last, user u (bad forces last to 1).
  task automatic chk_frame(input string tag, input logic [7:0] base, input int n,
                           input logic u, input logic bad);
    logic [9:0] e;
    chk({tag, "_cnt"}, obs_q.size() >= n, 1'b1);
    for (int i = 0; i < n && obs_q.size() > 0; i++) begin
      e = {base + 8'(i), i == n - 1, u | (bad && i == n - 1)};
      chk({tag, "_word"}, obs_q.pop_front(), e);
    end
  endtask

  task automatic clr();
    obs_q.delete(); obs32_q.delete();
    obs_tr = 0; obs_rn = 0; obs_lv = 0; o32_tr = 0; o32_rn = 0; o32_lv = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    bit bp_en;
    logic [5:0] w;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_mvalid", m_valid, 1'b0);
    chk("rst_sready", s_ready, 1'b0);
    chk("rst_status", {st_tr, st_rn, st_lv}, 3'b000);
    chk("rst_len", st_len, 16'd0);
    rst = 1'b0; #1;
    chk("post_rst_sready", s_ready, 1'b1);
    @(posedge clk); #1;
    clr();

    // legal frames: MIN and MAX length, back to back
    c0 = cyc;
    send(8'h10, 1'b0, 1'b0);
    chk("latency_vld", m_valid, 1'b1);
    chk("latency_dat", m_data, 8'h10);
    for (int i = 1; i < 4; i++) send(8'h10 + 8'(i), i == 3, 1'b0);
    send_frame(8'h20, 8, 1'b0);
    chk("b2b_cycles", cyc - c0, 12);
    drain();
    chk("legal_total", obs_q.size(), 12);
    chk_frame("legal4", 8'h10, 4, 1'b0, 1'b0);
    chk_frame("legal8", 8'h20, 8, 1'b0, 1'b0);
    chk("legal_pulses", obs_tr + obs_rn, 0);
`ifdef AXIS_FRAME_GUARD_LEN_REPORT_EN
    chk("legal_len", st_len, 16'd8);
    chk("legal_lv", obs_lv, 2);
`else
    chk("legal_len_tied", st_len, 16'd0);
    chk("legal_lv_tied", obs_lv, 0);
`endif
    clr();

    // runt
    send_frame(8'h30, 3, 1'b0);
    drain();
    chk("runt_total", obs_q.size(), 3);
    chk_frame("runt", 8'h30, 3, 1'b0, 1'b1);
    chk("runt_pulse", obs_rn, 1);
    chk("runt_no_trunc", obs_tr, 0);
`ifdef AXIS_FRAME_GUARD_LEN_REPORT_EN
    chk("runt_len", st_len, 16'd3);
`endif
    clr();

    // oversize: 12 in, 9 out, tail consumed at full rate
    c0 = cyc;
    send_frame(8'h40, 12, 1'b0);
    chk("over_cycles", cyc - c0, 12);
    drain();
    chk("over_total", obs_q.size(), 9);
    chk_frame("over", 8'h40, 9, 1'b0, 1'b1);
    chk("over_pulse", obs_tr, 1);
    chk("over_no_runt", obs_rn, 0);
`ifdef AXIS_FRAME_GUARD_LEN_REPORT_EN
    chk("over_len", st_len, 16'd9);
`endif
    send_frame(8'h50, 5, 1'b0);
    drain();
    chk_frame("after_over", 8'h50, 5, 1'b0, 1'b0);
    // input already marked bad passes unchanged
    send_frame(8'h60, 5, 1'b1);
    drain();
    chk_frame("pre_bad", 8'h60, 5, 1'b1, 1'b0);
    chk("clean_pulses", obs_tr + obs_rn, 1);
    clr();

    // keep counting on the 32-bit instance
    send32(4'hF, 1'b0); send32(4'hF, 1'b0); send32(4'h3, 1'b1);
    drain();
    chk("keep10_cnt", obs32_q.size(), 3);
    if (obs32_q.size() == 3) begin w = obs32_q[2]; chk("keep10_last", w, {4'h3, 1'b1, 1'b0}); end
    chk("keep10_trunc", o32_tr, 0);
`ifdef AXIS_FRAME_GUARD_LEN_REPORT_EN
    chk("keep10_len", u_len, 16'd10);
`endif
    obs32_q.delete();
    send32(4'hF, 1'b0); send32(4'hF, 1'b0); send32(4'h7, 1'b1);
    drain();
    chk("keep11_cnt", obs32_q.size(), 3);
    if (obs32_q.size() == 3) begin w = obs32_q[2]; chk("keep11_last", w, {4'h7, 1'b1, 1'b1}); end
    chk("keep11_trunc", o32_tr, 1);
    obs32_q.delete();
    send32(4'hF, 1'b0); send32(4'h0, 1'b0); send32(4'hF, 1'b0); send32(4'h3, 1'b1);
    drain();
    chk("keep0_cnt", obs32_q.size(), 4);
    if (obs32_q.size() == 4) begin w = obs32_q[3]; chk("keep0_last", w, {4'h3, 1'b1, 1'b0}); end
    chk("keep0_trunc", o32_tr, 1);
    chk("keep_runt", o32_rn, 0);
`ifdef AXIS_FRAME_GUARD_LEN_REPORT_EN
    chk("keep_lv", o32_lv, 3);
`else
    chk("keep_lv_tied", o32_lv, 0);
`endif
    clr();

    // random back-pressure scoreboard
    use_model = 1; bp_en = 1; m_len = 0; m_drop = 0; exp_tr = 0; exp_rn = 0;
    fork
      while (bp_en) begin @(posedge clk); #1; m_ready = ($urandom_range(0, 9) < 3); end
    join_none
    for (int f = 0; f < 200; f++) begin
      send_frame(8'($urandom_range(0, 255)), $urandom_range(1, 12), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
    end
    bp_en = 0;
    @(posedge clk); #2;
    m_ready = 1'b1;
    drain();
    use_model = 0;
    chk("sb_count", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) chk("sb_word", obs_q.pop_front(), exp_q.pop_front());
    chk("sb_trunc", obs_tr, exp_tr);
    chk("sb_runt", obs_rn, exp_rn);
    clr(); exp_q.delete();

    // reset mid-frame
    for (int i = 0; i < 3; i++) send(8'h70 + 8'(i), 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_mvalid", m_valid, 1'b0);
    chk("rstmid_sready", s_ready, 1'b0);
    rst = 1'b0; #1;
    chk("rstmid_sready_after", s_ready, 1'b1);
    clr();
`ifdef AXIS_FRAME_GUARD_LEN_REPORT_EN
    chk("rstmid_len", st_len, 16'd0);
`endif
    send_frame(8'h80, 6, 1'b0);
    drain();
    chk("rstmid_total", obs_q.size(), 6);
    chk_frame("rstmid_next", 8'h80, 6, 1'b0, 1'b0);
    clr();

    // reset while in DROP
    for (int i = 0; i < 10; i++) send(8'h90 + 8'(i), 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstdrop_mvalid", m_valid, 1'b0);
    chk("rstdrop_sready", s_ready, 1'b0);
    rst = 1'b0; #1;
    clr();
    send_frame(8'hA0, 5, 1'b0);
    drain();
    chk("rstdrop_total", obs_q.size(), 5);
    chk_frame("rstdrop_next", 8'hA0, 5, 1'b0, 1'b0);
    chk("rstdrop_pulses", obs_tr + obs_rn, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
